uart_bus_arbiter: RTL and testbench

//   Two-master Wishbone arbiter sharing the single UART slave port (data at adr 0, conf at adr 1).

---
 rtl/uart_bus_arbiter_if.sv | 54 +++++
 rtl/uart_bus_arbiter.sv | 118 +++++++++++
 tb/tb_uart_bus_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the UART slave port.
//   m0_* / m1_*  : master request inputs (cyc, stb, we, adr, sel, dat) and
//                  response outputs (dat_o, ack_o, err_o)
//   s_*          : shared UART slave port (request outputs, dat_i/ack_i inputs)
// Modport slave  : the arbiter's view (it is the slave of both masters).
// Modport master : the environment's view (masters plus the UART model).
interface uart_bus_arbiter_if;
  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic        m0_adr_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic        m1_adr_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_i;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic        s_adr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Two-master Wishbone arbiter in front of the single UART slave port.
// Round-robin grant held for the owner's whole cyc, plus a watchdog that
// aborts a beat the UART does not ack within TIMEOUT cycles.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   bus      master/slave bundle (uart_bus_arbiter_if.slave)
//   grant_o  one-hot current owner (bit N = master N), 00 when idle
module uart_bus_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_bus_arbiter_if.slave  bus,
  output logic [1:0]         grant_o
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic        req0, req1, own1, busy, abort;
  logic        o_cyc, o_stb, o_we, o_adr;
  logic [3:0]  o_sel;
  logic [31:0] o_dat;

  assign req0  = bus.m0_cyc_i & bus.m0_stb_i;
  assign req1  = bus.m1_cyc_i & bus.m1_stb_i;
  assign own1  = grant_q[1];
  assign busy  = (state_q == BUSY);
  assign abort = (state_q == ABORT);

  // Owner request mux; only forwarded to the UART while BUSY.
  assign o_cyc = own1 ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign o_stb = own1 ? bus.m1_stb_i : bus.m0_stb_i;
  assign o_we  = own1 ? bus.m1_we_i  : bus.m0_we_i;
  assign o_adr = own1 ? bus.m1_adr_i : bus.m0_adr_i;
  assign o_sel = own1 ? bus.m1_sel_i : bus.m0_sel_i;
  assign o_dat = own1 ? bus.m1_dat_i : bus.m0_dat_i;

  assign bus.s_cyc_o = busy & o_cyc;
  assign bus.s_stb_o = busy & o_stb;
  assign bus.s_we_o  = busy & o_we;
  assign bus.s_adr_o = busy & o_adr;
  assign bus.s_sel_o = busy ? o_sel : '0;
  assign bus.s_dat_o = busy ? o_dat : '0;

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;

  // Acks only pass through in BUSY, so a stray UART ack in IDLE/ABORT is dropped.
  assign bus.m0_ack_o = busy & grant_q[0] & bus.s_ack_i;
  assign bus.m1_ack_o = busy & grant_q[1] & bus.s_ack_i;
  assign bus.m0_err_o = abort & grant_q[0];
  assign bus.m1_err_o = abort & grant_q[1];

  assign grant_o = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          if (req0 && req1) grant_d = last_q ? 2'b01 : 2'b10;
          else              grant_d = req1 ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (!o_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = own1;
        end else if (o_stb && !bus.s_ack_i) begin
          if (wdog_q == WD_LAST) state_d = ABORT;
          else                   wdog_d  = wdog_q + WDW'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = own1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
module tb_uart_bus_arbiter;

  localparam logic [3:0]  M0_SEL  = 4'hF;
  localparam logic [31:0] M0_DAT  = 32'hC0DE_0000;
  localparam logic [3:0]  M1_SEL  = 4'h1;
  localparam logic [31:0] M1_DAT  = 32'h0000_0041;
  localparam logic [31:0] S_RDATA = 32'hA5A5_5A5A;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_bus_arbiter_if bus ();

  uart_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] cyc;   // {m1, m0}
    logic [1:0] stb;
    logic [1:0] we;
    logic [1:0] adr;
    logic       ack;   // s_ack_i
    logic [1:0] eg;    // expected grant_o
    logic       ecyc, estb, ewe, eadr;
    logic [1:0] eack;  // {m1, m0}
    logic [1:0] eerr;  // {m1, m0}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] cyc, input logic [1:0] stb,
                              input logic [1:0] we, input logic [1:0] adr,
                              input logic ack, input logic [1:0] eg,
                              input logic ecyc, input logic estb,
                              input logic ewe, input logic eadr,
                              input logic [1:0] eack, input logic [1:0] eerr);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.ack = ack;
    v.eg = eg; v.ecyc = ecyc; v.estb = estb; v.ewe = ewe; v.eadr = eadr;
    v.eack = eack; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, grant, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
            bus.s_sel_o, bus.s_dat_o, bus.m0_ack_o, bus.m1_ack_o,
            bus.m0_err_o, bus.m1_err_o};
  endfunction

  task automatic run_range(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i < hi; i++) begin
      v = tbl[i];
      @(negedge clk);
      bus.m0_cyc_i = v.cyc[0]; bus.m1_cyc_i = v.cyc[1];
      bus.m0_stb_i = v.stb[0]; bus.m1_stb_i = v.stb[1];
      bus.m0_we_i  = v.we[0];  bus.m1_we_i  = v.we[1];
      bus.m0_adr_i = v.adr[0]; bus.m1_adr_i = v.adr[1];
      bus.s_ack_i  = v.ack;
      #1;
      chk($sformatf("vec%0d ctrl", i),
          {54'd0, grant, bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o,
           bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o},
          {54'd0, v.eg, v.ecyc, v.estb, v.ewe, v.eadr, v.eack, v.eerr});
      if (v.estb)
        chk($sformatf("vec%0d sel/dat", i), {28'd0, bus.s_sel_o, bus.s_dat_o},
            v.eg[1] ? {28'd0, M1_SEL, M1_DAT} : {28'd0, M0_SEL, M0_DAT});
      if (|v.eack)
        chk($sformatf("vec%0d rdata", i), {bus.m1_dat_o, bus.m0_dat_o}, {S_RDATA, S_RDATA});
    end
  endtask

  int na;

  initial begin
    rst = 1'b1;
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = 0;
    bus.m0_sel_i = M0_SEL; bus.m0_dat_i = M0_DAT;
    bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = 0;
    bus.m1_sel_i = M1_SEL; bus.m1_dat_i = M1_DAT;
    bus.s_dat_i = S_RDATA; bus.s_ack_i = 0;

    // Tie out of reset -> m0; m0 re-requests in the idle cycle -> tie -> m1.
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 0, 2'b01, 1, 1, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 1, 2'b01, 1, 1, 0, 0, 2'b01, 2'b00));
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 0, 2'b10, 1, 1, 1, 1, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b10, 2'b10, 1, 2'b10, 1, 1, 1, 1, 2'b10, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b01, 1, 1, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b01, 1, 1, 0, 0, 2'b01, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    // m0 read of adr 0, UART acks 3 cycles after s_stb rises.
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 0, 2'b01, 1, 1, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 2'b00, 1, 2'b01, 1, 1, 0, 0, 2'b01, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    na = tbl.size();
    // Watchdog: m1 never acked, err 8 cycles after s_stb rises; stray ack in ABORT ignored.
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 2'b10, 1, 1, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0, 2'b00, 2'b10));
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2'b11, 2'b00, 2'b00, 1, 2'b01, 1, 1, 0, 0, 2'b01, 2'b00));
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    // Spurious UART ack while idle.
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00));

    @(negedge clk);
    #1;
    chk("reset outputs", all_outs(), 64'd0);
    rst = 1'b0;

    run_range(0, na);

    // m1 owns the bus for three write beats while m0 keeps requesting.
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0; bus.m0_adr_i = 0;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_adr_i = 1;
    bus.m1_sel_i = 4'b0001; bus.m1_dat_i = 32'h03; bus.s_ack_i = 0;
    #1 chk("t3 idle grant", {62'd0, grant}, 64'd0);
    @(negedge clk);
    #1 chk("t3 beat1 grant", {62'd0, grant}, 64'd2);
    chk("t3 beat1 bus", {bus.s_we_o, bus.s_adr_o, bus.s_sel_o, bus.s_dat_o},
        {1'b1, 1'b1, 4'b0001, 32'h03});
    bus.s_ack_i = 1;
    #1 chk("t3 beat1 ack", {bus.m1_ack_o, bus.m0_ack_o}, 64'd2);
    @(negedge clk);
    bus.s_ack_i = 0; bus.m1_stb_i = 0;
    #1 chk("t3 gap", {bus.s_cyc_o, bus.s_stb_o, grant}, {1'b1, 1'b0, 2'b10});
    @(negedge clk);
    bus.m1_stb_i = 1; bus.m1_adr_i = 0; bus.m1_dat_i = 32'h41;
    #1 chk("t3 beat2 bus", {bus.s_adr_o, bus.s_dat_o, grant}, {1'b0, 32'h41, 2'b10});
    bus.s_ack_i = 1;
    #1 chk("t3 beat2 ack", {bus.m1_ack_o, bus.m0_ack_o}, 64'd2);
    @(negedge clk);
    bus.m1_dat_i = 32'h42;
    #1 chk("t3 beat3 bus", {bus.s_sel_o, bus.s_dat_o, grant}, {4'b0001, 32'h42, 2'b10});
    chk("t3 beat3 ack", {bus.m1_ack_o, bus.m0_ack_o}, 64'd2);
    @(negedge clk);
    bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
    #1 chk("t3 m1 drop", {grant, bus.s_cyc_o}, {2'b10, 1'b0});
    @(negedge clk);
    #1 chk("t3 reidle", {62'd0, grant}, 64'd0);
    @(negedge clk);
    #1 chk("t3 m0 grant", {grant, bus.s_stb_o, bus.s_we_o}, {2'b01, 1'b1, 1'b0});
    bus.s_ack_i = 1;
    #1 chk("t3 m0 ack", {bus.m1_ack_o, bus.m0_ack_o}, 64'd1);
    @(negedge clk);
    bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
    bus.m1_sel_i = M1_SEL; bus.m1_dat_i = M1_DAT;
    @(negedge clk);

    run_range(na, tbl.size());

    // Reset in the middle of a beat, then a tie must go to m0.
    @(negedge clk);
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    #1 chk("t5 idle", {62'd0, grant}, 64'd0);
    @(negedge clk);
    #1 chk("t5 busy", {bus.s_stb_o, grant}, {1'b1, 2'b10});
    #1 rst = 1'b1;
    #1 chk("t5 async reset", all_outs(), 64'd0);
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    #1 chk("t5 held reset", {62'd0, grant}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("t5 tie after reset", {bus.s_stb_o, grant, bus.s_sel_o, bus.s_dat_o},
           {1'b1, 2'b01, M0_SEL, M0_DAT});
    @(negedge clk);
    bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
